// File: rtl/gb_timer.sv
// Game Boy DIV/TIMA/TMA/TAC timer: free-running system counter, TAC-selected
// falling-edge TIMA increment, delayed TMA reload and one-clock interrupt pulse.
module gb_timer #(
  parameter int SYS_CNT_WIDTH = 16
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       tick_in,
  input  logic [1:0] addr_in,
  input  logic       wr_in,
  input  logic [7:0] wdata_in,
  output logic [7:0] rdata_out,
  output logic       irq_out
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_OVF_WAIT = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [SYS_CNT_WIDTH-1:0] sys_cnt_q, sys_cnt_d;
  logic [7:0]               tima_q, tima_d;
  logic [7:0]               tma_q, tma_d;
  logic [2:0]               tac_q, tac_d;
  logic [1:0]               tick_cnt_q, tick_cnt_d;
  logic                     sel_q;
  logic                     irq_q, irq_d;

  logic div_wr_s, tima_wr_s, tma_wr_s, tac_wr_s;
  logic sel_s, fall_s, ovf_s, reload_s;

  // Enabled timer input: the TAC-selected counter bit gated by tac[2].
  function automatic logic timer_bit(input logic [2:0] tac,
                                     input logic [SYS_CNT_WIDTH-1:0] cnt);
    logic b;
    case (tac[1:0])
      2'b00:   b = cnt[9];
      2'b01:   b = cnt[3];
      2'b10:   b = cnt[5];
      2'b11:   b = cnt[7];
      default: b = 1'b0;
    endcase
    return tac[2] & b;
  endfunction

  assign div_wr_s  = wr_in & (addr_in == 2'd0);
  assign tima_wr_s = wr_in & (addr_in == 2'd1);
  assign tma_wr_s  = wr_in & (addr_in == 2'd2);
  assign tac_wr_s  = wr_in & (addr_in == 2'd3);

  // sel_q holds the previous clock's timer input, so a DIV or TAC write that drops it also counts.
  assign sel_s    = timer_bit(tac_q, sys_cnt_q);
  assign fall_s   = sel_q & ~sel_s;
  assign ovf_s    = (state_q == ST_RUN) & fall_s & ~tima_wr_s & (tima_q == 8'hFF);
  assign reload_s = (state_q == ST_OVF_WAIT) & tick_in & (tick_cnt_q == 2'd3);

  // Register file and counter update with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_RUN;
      sys_cnt_q  <= '0;
      tima_q     <= 8'h00;
      tma_q      <= 8'h00;
      tac_q      <= 3'b000;
      tick_cnt_q <= 2'd0;
      sel_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sys_cnt_q  <= sys_cnt_d;
      tima_q     <= tima_d;
      tma_q      <= tma_d;
      tac_q      <= tac_d;
      tick_cnt_q <= tick_cnt_d;
      sel_q      <= sel_s;
      irq_q      <= irq_d;
    end
  end

  // CPU-writable registers and the system counter.
  always_comb begin
    sys_cnt_d = sys_cnt_q;
    tma_d     = tma_q;
    tac_d     = tac_q;
    if (div_wr_s) begin
      sys_cnt_d = '0;
    end else if (tick_in) begin
      sys_cnt_d = sys_cnt_q + SYS_CNT_WIDTH'(1);
    end else begin
      sys_cnt_d = sys_cnt_q;
    end
    if (tma_wr_s) begin
      tma_d = wdata_in;
    end else begin
      tma_d = tma_q;
    end
    if (tac_wr_s) begin
      tac_d = wdata_in[2:0];
    end else begin
      tac_d = tac_q;
    end
  end

  // Overflow state machine: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (ovf_s) begin
          state_d = ST_OVF_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_OVF_WAIT: begin
        if (reload_s || tima_wr_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_OVF_WAIT;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Overflow state machine: TIMA, reload tick counter and interrupt.
  always_comb begin
    tima_d     = tima_q;
    tick_cnt_d = tick_cnt_q;
    irq_d      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (tima_wr_s) begin
          tima_d = wdata_in;
        end else if (ovf_s) begin
          tima_d     = 8'h00;
          tick_cnt_d = 2'd0;
        end else if (fall_s) begin
          tima_d = tima_q + 8'd1;
        end else begin
          tima_d = tima_q;
        end
      end
      ST_OVF_WAIT: begin
        // Reload uses the post-write TMA; a TIMA write on this clock loses.
        if (reload_s) begin
          tima_d = tma_d;
          irq_d  = 1'b1;
        end else if (tima_wr_s) begin
          tima_d = wdata_in;
        end else if (tick_in) begin
          tick_cnt_d = tick_cnt_q + 2'd1;
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      default: begin
        tima_d     = tima_q;
        tick_cnt_d = 2'd0;
      end
    endcase
  end

  // Combinational register read.
  always_comb begin
    rdata_out = 8'h00;
    case (addr_in)
      2'd0:    rdata_out = sys_cnt_q[15:8];
      2'd1:    rdata_out = tima_q;
      2'd2:    rdata_out = tma_q;
      2'd3:    rdata_out = {5'b11111, tac_q};
      default: rdata_out = 8'h00;
    endcase
  end

  assign irq_out = irq_q;

endmodule

// File: tb/tb_gb_timer.sv
// Directed bench for gb_timer: stimulus pushes expected reads/irq facts into a
// queue; a negedge monitor pops and compares against the DUT.
module tb_gb_timer;

  logic       clk_in;
  logic       rst_n_in;
  logic       tick_in;
  logic [1:0] addr_in;
  logic       wr_in;
  logic [7:0] wdata_in;
  logic [7:0] rdata_out;
  logic       irq_out;

  gb_timer #(.SYS_CNT_WIDTH(16)) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .tick_in   (tick_in),
    .addr_in   (addr_in),
    .wr_in     (wr_in),
    .wdata_in  (wdata_in),
    .rdata_out (rdata_out),
    .irq_out   (irq_out)
  );

  // kind 0: rdata_out, kind 1: irq_out level, kind 2: cumulative irq pulses
  typedef struct {
    int         kind;
    logic [1:0] addr;
    logic [7:0] exp;
    string      name;
  } chk_t;

  chk_t q[$];
  logic rd_en;
  int   tests_run;
  int   tests_failed;
  int   irq_seen;
  int   irq_exp;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Monitor: counts irq pulses and checks one queued expectation per strobed cycle.
  always @(negedge clk_in) begin
    chk_t c;
    int   act;
    if (irq_out === 1'b1) irq_seen++;
    if (rd_en) begin
      tests_run++;
      if (q.size() == 0) begin
        tests_failed++;
        $display("FAIL empty_queue: check strobed with no expectation queued");
      end else begin
        c = q.pop_front();
        case (c.kind)
          0:       act = int'(rdata_out);
          1:       act = int'(irq_out);
          default: act = irq_seen;
        endcase
        if (act !== int'(c.exp)) begin
          tests_failed++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_tick(input int n);
    tick_in = 1'b1;
    repeat (n) cyc();
    tick_in = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    addr_in  = a;
    wdata_in = d;
    wr_in    = 1'b1;
    cyc();
    wr_in    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    cyc();
    rst_n_in = 1'b1;
  endtask

  task automatic push_chk(input int k, input logic [1:0] a, input logic [7:0] e,
                          input string nm);
    chk_t c;
    c.kind = k;
    c.addr = a;
    c.exp  = e;
    c.name = nm;
    q.push_back(c);
    addr_in = a;
    rd_en   = 1'b1;
    cyc();
    rd_en   = 1'b0;
  endtask

  task automatic expect_rd(input logic [1:0] a, input logic [7:0] e, input string nm);
    push_chk(0, a, e, nm);
  endtask

  task automatic expect_irq(input logic e, input string nm);
    push_chk(1, 2'd0, {7'b0000000, e}, nm);
  endtask

  task automatic expect_irq_total(input string nm);
    push_chk(2, 2'd0, 8'(irq_exp), nm);
  endtask

  // Reset, then program TMA=F0, TIMA=FF, TAC=05 and run into OVF_WAIT.
  task automatic enter_ovf();
    do_reset();
    do_write(2'd2, 8'hF0);
    do_write(2'd1, 8'hFF);
    do_write(2'd3, 8'h05);
    do_tick(16);
    idle(1);
  endtask

  initial begin
    rst_n_in     = 1'b0;
    tick_in      = 1'b0;
    addr_in      = 2'd0;
    wr_in        = 1'b0;
    wdata_in     = 8'h00;
    rd_en        = 1'b0;
    tests_run    = 0;
    tests_failed = 0;
    irq_seen     = 0;
    irq_exp      = 0;
    idle(2);

    // Reset state and basic count
    do_reset();
    expect_rd(2'd0, 8'h00, "rst_div");
    expect_rd(2'd1, 8'h00, "rst_tima");
    expect_rd(2'd2, 8'h00, "rst_tma");
    expect_rd(2'd3, 8'hF8, "rst_tac");
    expect_irq(1'b0, "rst_irq");
    do_write(2'd3, 8'h05);
    expect_rd(2'd3, 8'hFD, "tac_rd");
    do_tick(64);
    idle(1);
    expect_rd(2'd1, 8'h04, "basic_tima");
    expect_irq_total("basic_no_irq");

    // Overflow and reload
    enter_ovf();
    expect_rd(2'd1, 8'h00, "ovf_tima_zero");
    do_tick(3);
    expect_rd(2'd1, 8'h00, "ovf_wait_tima");
    expect_irq(1'b0, "ovf_irq_before_reload");
    do_tick(1);
    irq_exp = irq_exp + 1;
    expect_irq(1'b1, "reload_irq_high");
    expect_irq(1'b0, "reload_irq_low");
    expect_rd(2'd1, 8'hF0, "reload_tima");
    expect_irq_total("reload_irq_count");

    // Cancel by TIMA write during OVF_WAIT
    enter_ovf();
    do_tick(2);
    do_write(2'd1, 8'h10);
    expect_rd(2'd1, 8'h10, "cancel_tima");
    do_tick(8);
    idle(1);
    expect_rd(2'd1, 8'h10, "cancel_no_reload");
    expect_irq_total("cancel_no_irq");

    // DIV-write glitch with bit 3 high
    do_reset();
    do_write(2'd3, 8'h05);
    do_tick(8);
    do_write(2'd0, 8'h5A);
    expect_rd(2'd0, 8'h00, "glitch_div");
    expect_rd(2'd1, 8'h01, "glitch_tima_inc");
    idle(4);
    expect_rd(2'd1, 8'h01, "glitch_tima_once");
    do_reset();
    do_write(2'd3, 8'h04);
    do_tick(8);
    do_write(2'd0, 8'h00);
    expect_rd(2'd0, 8'h00, "noglitch_div");
    expect_rd(2'd1, 8'h00, "noglitch_tima");

    // DIV rate and wrap
    do_reset();
    do_write(2'd3, 8'h00);
    do_tick(512);
    expect_rd(2'd0, 8'h02, "div_512");
    expect_rd(2'd1, 8'h00, "div_512_tima");
    do_tick(65280 - 512);
    expect_rd(2'd0, 8'hFF, "div_65280");
    do_tick(256);
    expect_rd(2'd0, 8'h00, "div_wrap");
    expect_rd(2'd1, 8'h00, "div_wrap_tima");

    // Reset during OVF_WAIT
    enter_ovf();
    do_tick(2);
    do_reset();
    do_tick(8);
    idle(1);
    expect_rd(2'd1, 8'h00, "rstovf_tima");
    expect_rd(2'd2, 8'h00, "rstovf_tma");
    expect_rd(2'd0, 8'h00, "rstovf_div");
    expect_rd(2'd3, 8'hF8, "rstovf_tac");
    expect_irq_total("rstovf_no_irq");

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gb_timer.md
# gb_timer

- Game Boy DIV/TIMA/TMA/TAC timer block. Clocked by the system clock and advanced by the T-cycle enable from the upstream clock-divider event counter.
- Keeps the 16-bit internal system counter and exposes DIV as its upper byte.
- Increments TIMA on falling edges of the TAC-selected counter bit.
- On TIMA overflow, performs the delayed TMA reload and raises a one-clock timer interrupt pulse for the interrupt controller.

## Interface

Parameters:

- SYS_CNT_WIDTH, default 16: internal system counter width. Must be ≥ 16; DIV is always bits [15:8].

Ports:

- clk_in, input, 1: system clock.
- rst_n_in, input, 1: reset, synchronous, active-low.
- tick_in, input, 1: T-cycle enable (4.194304 MHz rate). One clock wide; may be high on consecutive clocks.
- addr_in, input, 2: register select. 0 = DIV (FF04), 1 = TIMA (FF05), 2 = TMA (FF06), 3 = TAC (FF07).
- wr_in, input, 1: write strobe. A write takes effect on the clock where it is high.
- wdata_in, input, 8: write data.
- rdata_out, output, 8: combinational read of the addressed register.
- irq_out, output, 1: timer interrupt request. Held high for exactly one clock.

## Operation

Reset (rst_n_in low at a clock edge):

- sys_cnt, TIMA, TMA and TAC all go to 0.
- State goes to RUN; the tick counter goes to 0.
- irq_out goes to 0 and the edge-detect register goes to 0.
- All reset effects are visible on the next clock. Reset overrides all other activity, including an in-progress overflow.

sys_cnt:

- Increments by 1 on each tick_in, wrapping modulo 2^SYS_CNT_WIDTH.
- A write to DIV clears sys_cnt to 0 and takes priority over tick_in in the same clock.

Reads:

- DIV = sys_cnt[15:8].
- TIMA and TMA read as stored.
- TAC reads {5'b11111, tac[2:0]}.

TAC:

- Write stores wdata_in[2:0].
- tac[2] is the enable.
- tac[1:0] selects the sys_cnt bit: 00 → bit 9, 01 → bit 3, 10 → bit 5, 11 → bit 7.

Edge detect:

- sel_sig = tac[2] & sys_cnt[sel]. It is recomputed from post-update values and registered every clock, not only on tick clocks.
- A 1→0 transition of sel_sig increments TIMA.
- Consequently, a DIV write while the selected bit is 1 causes an increment.
- Likewise, a TAC write that disables the timer or changes the selected bit from a 1-bit to a 0-bit causes an increment.

State machine:

- RUN:
  - A TIMA increment from 0xFF sets TIMA to 0x00, enters OVF_WAIT and clears the tick counter.
  - An increment below 0xFF adds 1.
- OVF_WAIT:
  - TIMA reads 0x00. Edge increments are ignored.
  - The tick counter (2-bit) counts tick_in.
  - On the clock of the 4th tick: TIMA ← TMA (TMA value after any same-clock TMA write), irq_out = 1 on the following clock, state → RUN.
  - A CPU TIMA write during OVF_WAIT before the 4th tick stores wdata_in, cancels the reload and the interrupt, and sets state → RUN.
  - A TIMA write on the reload clock is ignored; TMA wins.

Write priority:

- A CPU TIMA write in RUN beats a same-clock edge increment. The written value is stored and no increment occurs.
- TMA writes never affect TIMA except through a reload.

## Timing

- Register writes are visible on rdata_out one clock after the wr_in clock.
- TIMA increment:
  - Edge detection is based on the registered sel_sig.
  - TIMA updates one clock after the clock on which sys_cnt's selected bit falls.
  - Cycle-accurate relative to tick_in: increments occur every 1024/16/64/256 ticks for tac[1:0] = 00/01/10/11.
- Overflow to reload:
  - Exactly 4 tick_in pulses after the overflow clock.
  - irq_out is asserted one clock after the reload, for one clock.
- rdata_out is purely combinational on addr_in and the current registers; there is no read strobe and no read side effects.
- irq_out is registered and glitch-free.

## Test plan

- Basic count: reset, write TAC = 0x05, apply 64 ticks → TIMA = 0x04, irq_out never high.
- Overflow and reload: TMA = 0xF0, TIMA = 0xFF, TAC = 0x05, apply 16 ticks → TIMA = 0x00. After 4 further ticks → TIMA = 0xF0, and irq_out is high for exactly one clock, one clock after the reload.
- Cancel: same setup; write TIMA = 0x10 after 2 ticks of OVF_WAIT → TIMA = 0x10, no irq_out, no reload after further ticks.
- DIV-write glitch: TAC = 0x05, apply 8 ticks (bit 3 = 1), write DIV → DIV reads 0x00 and TIMA increments by exactly 1 with no further ticks. TAC = 0x04 with the same sequence → no increment.
- DIV rate/wrap: TAC = 0, apply 512 ticks → DIV = 0x02. Continue to 65536 ticks total → DIV = 0x00. TIMA stays 0 throughout.
- Reset mid-overflow: enter OVF_WAIT, assert rst_n_in low for one clock, then apply 8 ticks → TIMA, TMA, DIV all 0, TAC reads 0xF8, irq_out never high.
